// File: rtl/debounce_bank_if.sv
// Bus bundle for debounce_bank: raw button inputs and the debounced level/strobe outputs.
// slave is the debouncer side; master is the side that drives the raw pins and consumes results.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] long_press;

  modport slave (
    input  btn_in,
    output btn_out,
    output rise_pulse,
    output fall_pulse,
    output long_press
  );

  modport master (
    output btn_in,
    input  btn_out,
    input  rise_pulse,
    input  fall_pulse,
    input  long_press
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: two-flop synchroniser, per-channel stability
// counter, registered rise/fall strobes and an optional long-press strobe.
// Optional feature macro: DEBOUNCE_BANK_LONG_PRESS_EN (long-press counters; otherwise long_press = 0).
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 25,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned LONG_W        = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] s1_q, s1_d;
  logic [CHANNELS-1:0] s2_q, s2_d;
  logic [CHANNELS-1:0] btn_q, btn_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Synchronise inputs and accept a new level only after it has held for STABLE_CYCLES samples.
  always_comb begin
    s1_d   = bus.btn_in;
    s2_d   = s1_q;
    btn_d  = btn_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != btn_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btn_d[i]  = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      btn_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      btn_q  <= btn_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.btn_out    = btn_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [CHANNELS-1:0] long_q, long_d;
  logic [LONG_W-1:0]   long_cnt_q [CHANNELS];
  logic [LONG_W-1:0]   long_cnt_d [CHANNELS];

  // Count cycles held high since the rise (counter is 0 on the rise cycle); saturate so it fires once.
  always_comb begin
    long_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      long_cnt_d[i] = '0;
      if (btn_q[i]) begin
        if (long_cnt_q[i] != LONG_MAX) begin
          long_cnt_d[i] = long_cnt_q[i] + LONG_W'(1);
          long_d[i]     = (long_cnt_q[i] == LONG_LAST);
        end else begin
          long_cnt_d[i] = LONG_MAX;
        end
      end
    end
  end

  // Long-press state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) long_cnt_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int unsigned i = 0; i < CHANNELS; i++) long_cnt_q[i] <= long_cnt_d[i];
    end
  end

  assign bus.long_press = long_q;
`else
  // Long-press sizing parameters have no role in this build.
  localparam int unsigned LONG_CFG_UNUSED = LONG_CYCLES + LONG_W;

  assign bus.long_press = '0;
`endif

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for push-buttons and switches. Each channel has:
- a two-flop synchroniser;
- a per-channel stability counter;
- registered one-cycle rise and fall pulses;
- an optional long-press detector.

It sits between the board input pins and the control FSMs, so every downstream block receives a clean level and single-cycle edge strobes.

## Interface
- CHANNELS, 4: number of independent input channels (≥1)
- STABLE_CYCLES, 25: consecutive synchronised samples a new level must hold before it is accepted (≥1)
- CNT_W, 20: stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES
- LONG_CYCLES, 1000: cycles `btn_out` must stay high to flag a long press (≥1; used only when the macro is defined)
- LONG_W, 24: long-press counter width; must satisfy 2^LONG_W > LONG_CYCLES

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- btn_in  input  CHANNELS  raw asynchronous inputs, active-high
- btn_out  output  CHANNELS  debounced level per channel
- rise_pulse  output  CHANNELS  one-cycle strobe when `btn_out` goes 0→1
- fall_pulse  output  CHANNELS  one-cycle strobe when `btn_out` goes 1→0
- long_press  output  CHANNELS  one-cycle strobe on long-press detection

## Operation
- **Independence:** channels are fully independent; all per-channel state is replicated CHANNELS times.
- **Synchroniser:** `btn_in[i]` passes through two flops (s1, s2). Only s2 is used for decisions.
- **Stability counter:**
  - If s2 equals `btn_out[i]`, cnt is cleared to 0.
  - If s2 differs and cnt == STABLE_CYCLES-1, then on that edge `btn_out[i]` takes the s2 value and cnt clears.
  - If s2 differs otherwise, cnt increments.
- **Glitch rejection:** any single sample equal to the current output restarts the count. cnt never exceeds STABLE_CYCLES-1.
- **Edge strobes:** `rise_pulse[i]` / `fall_pulse[i]` are registered. They assert in the same cycle `btn_out[i]` first shows the new level, for exactly one cycle.
- **Simultaneous events:** channels changing on the same edge produce strobes on the same edge. Rise and fall never assert together on one channel.
- **Reset (async, mid-operation included):** while `rst_n` is low, all of the following are 0:
  - s1, s2, cnt, long counters;
  - `btn_out`, `rise_pulse`, `fall_pulse`, `long_press`.
- **After reset release:** a held-high input produces a normal debounced rise after the full latency. No strobe is generated by the reset itself.

## Timing
- Let E0 be the first clk edge that samples a new `btn_in[i]` level into s1.
- s2 holds the new level after E0+1.
- `btn_out[i]` and the edge strobe change at edge E0+STABLE_CYCLES+1, provided the input holds.
- Total latency is STABLE_CYCLES+1 clock edges. Example: STABLE_CYCLES=1 gives 2 edges.
- A pulse shorter than STABLE_CYCLES synchronised samples is never passed.
- Long press: the counter starts at 0 on the cycle `rise_pulse` asserts and increments each cycle while `btn_out` stays 1.
  - `long_press[i]` asserts for one cycle on the edge where the counter reaches LONG_CYCLES, i.e. LONG_CYCLES edges after `rise_pulse`.
  - It fires at most once per press.
  - The counter holds (saturates) until `btn_out` falls, then clears.

## Configuration
- Macro: `DEBOUNCE_BANK_LONG_PRESS_EN`.
- **Defined:** per-channel long-press counters and detection are built exactly as specified above.
- **Undefined:**
  - No long-press counters are synthesised.
  - `long_press` is driven constant 0.
  - LONG_CYCLES and LONG_W are ignored.
  - The port list is unchanged in both builds.

## Test plan
- **Basic latency:** CHANNELS=4, STABLE_CYCLES=4. Drive `btn_in[0]` 0→1 and hold.
  - Required: `btn_out[0]` and `rise_pulse[0]` rise 5 edges after the sampling edge.
  - Required: `rise_pulse` is high exactly 1 cycle; other channels stay 0.
- **Glitch rejection:** STABLE_CYCLES=4. Apply 3-cycle high pulses separated by 1-cycle lows on `btn_in[1]`.
  - Required: `btn_out[1]` stays 0 and no strobes appear.
- **Release path:** after a stable high on channel 2, drop it to 0 and hold.
  - Required: `fall_pulse[2]` is a single cycle, 5 edges after the sampling edge.
  - Required: `rise_pulse[2]` stays 0 throughout.
- **Simultaneous channels:** drive all channels 0→1 on the same edge.
  - Required: `rise_pulse` = 4'b1111 for one cycle, then 4'b0000.
- **Reset mid-count:** start a transition on channel 3 and pull `rst_n` low after 2 cycles.
  - Required: all outputs read 0 immediately, asynchronously.
  - With input still high after release: rise occurs STABLE_CYCLES+1 edges after the first post-reset sampling edge.
- **Long press (macro defined):** LONG_CYCLES=10, hold channel 0 high for 30 cycles.
  - Required: `long_press[0]` pulses once, 10 edges after `rise_pulse[0]`.
  - Required: no second pulse occurs.
  - With the macro undefined, the same stimulus leaves `long_press` at 0.
